sq_stream_tx: RTL and testbench
===============================

Name: sq_stream_tx

Overview:
- Serial bit-stream transmitter: the sending end of the single-bit serial link consumed by the sequence detector (SQD).
- Accepts a parallel frame of up to WIDTH bits through a valid/ready load handshake and shifts it out MSB-first, one bit per clock, on out_data.
- Inserts a fixed idle gap between frames.
- Used to drive detector inputs on-chip and in loopback benches.

Parameters:
- WIDTH, 16, maximum frame length in bits.
- LEN_W, 5, width of load_len; must satisfy 2^LEN_W > WIDTH.
- GAP, 2, idle cycles inserted after each frame; 0 is legal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  frame offered on load_data/load_len.
- load_ready  output  1  block can accept a frame this cycle.
- load_data  input  WIDTH  frame; bit load_len-1 is sent first.
- load_len  input  LEN_W  frame length in bits; 0 or any value > WIDTH means WIDTH.
- out_data  output  1  serial bit; 0 when out_valid=0.
- out_valid  output  1  out_data carries a frame bit this cycle.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Reset: rst is sampled on the clock edge only. The cycle after rst is seen high: out_data=0, out_valid=0, load_ready=1, busy=0, done=0, state=IDLE, bit counter=0, gap counter=0, shift register cleared.
- rst asserted mid-frame or mid-gap aborts the frame immediately. No done pulse is produced.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1, out_valid=0.
  - Handshake fires when load_valid && load_ready at the rising edge.
  - On that edge: capture load_data, and the effective length L (1..WIDTH) from load_len, into a shift register and counter.
  - Go to SHIFT.
- SHIFT:
  - out_valid=1, load_ready=0, busy=1.
  - Latency: the first bit (load_data[L-1]) appears on out_data in the cycle after the accepting edge.
  - Each subsequent cycle presents the next lower bit, ending with load_data[0].
  - A frame occupies exactly L consecutive cycles with out_valid=1; there are no bubbles.
  - Bits load_data[WIDTH-1:L] are ignored.
  - done=1 only in the cycle carrying bit 0.
  - After the last bit: go to GAP if GAP>0, else to IDLE.
- GAP:
  - out_valid=0, out_data=0, load_ready=0, busy=1, for exactly GAP cycles.
  - Then go to IDLE.
- Turnaround: load_ready rises GAP+1 cycles after the done cycle (1 cycle when GAP=0). The earliest next frame therefore starts GAP+2 cycles after the previous done.
- load_valid while load_ready=0 is ignored. There is no buffering, and load_data may change freely.
- load_data/load_len are sampled only on the accepting edge; later changes do not affect the frame in flight.
- Counters are sized from LEN_W and GAP. No wrap-around is permitted: the bit counter decrements from L-1 to 0 and stops.

Optional Feature:
- Macro: SQ_TX_REPEAT_EN.
- Defined:
  - Adds input port `repeat` (1 bit).
  - If repeat=1 in the done cycle, the block runs the normal GAP and then re-enters SHIFT with the same captured frame and length.
  - No handshake is needed; load_ready stays 0 and busy stays 1.
  - If repeat=0 in the done cycle, behaviour is as without the macro.
  - rst clears the repeat state.
- Undefined: no repeat port; every frame is sent once.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, with load_valid=1 -> out_data=0, out_valid=0, load_ready=1, busy=0, done=0. No frame is accepted while rst=1.
2. Basic frame (GAP=2): load_data=16'h00B6, load_len=8, accepted at edge N -> cycles N+1..N+8 show out_data=1,0,1,1,0,1,1,0 with out_valid=1. done=1 only at N+8. Cycles N+9..N+10 have out_valid=0. load_ready=1 at N+11.
3. Full length via len=0: load_data=16'hA5F0, load_len=0 -> 16 bits 1010010111110000 in consecutive cycles, and done on the 16th bit.
4. Ignored load: during bit 3 of test 2, drive load_valid=1 with load_data=16'hFFFF -> stream unchanged, load_ready=0. Only the next load after load_ready=1 is accepted.
5. Reset mid-frame: assert rst for 1 cycle at bit 4 of a len=8 frame -> next cycle all outputs at reset values, with no done. A following load of 16'h0003, len=2 sends 1,1 normally.
6. Loopback: drive SQD in_data from out_data and send a frame containing the detector's target pattern -> SQD out_data asserts in the expected cycle. With SQ_TX_REPEAT_EN and repeat=1, the frame repeats after each GAP and SQD fires once per repetition.

Source files
------------

// File: rtl/sq_stream_tx_if.sv
// sq_stream_tx_if: load handshake and serial output bundle
// for the serial bit-stream transmitter.
interface sq_stream_tx_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             out_data;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output load_len,
    input  load_ready,
    input  out_data,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_len,
    output load_ready,
    output out_data,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/sq_stream_tx.sv
// sq_stream_tx: MSB-first serial frame transmitter with idle gap.
// Define SQ_TX_REPEAT_EN to add the repeat_frame input (frame replay).
module sq_stream_tx #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int GAP   = 2
) (
  input logic clk,
  input logic rst,
`ifdef SQ_TX_REPEAT_EN
  input logic repeat_frame,
`endif
  sq_stream_tx_if.slave bus
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [LEN_W-1:0] bcnt;
  logic [GW-1:0]    gcnt;
  logic             tx_bit;
  logic             tx_valid;
  logic             rdy;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] eff_frame;
  logic [LEN_W-1:0] st_len;
  logic [WIDTH-1:0] st_frame;

  // Frame is left-aligned so the first bit always sits at the MSB.
  always_comb begin
    eff_len = bus.load_len;
    if (bus.load_len == '0 || bus.load_len > LEN_MAX)
      eff_len = LEN_MAX;
    eff_frame = bus.load_data << (WIDTH - int'(eff_len));
  end

`ifdef SQ_TX_REPEAT_EN
  logic [WIDTH-1:0] frame_q;
  logic [LEN_W-1:0] len_q;
  logic             rpt_q;

  assign st_frame = (state == ST_IDLE) ? eff_frame : frame_q;
  assign st_len   = (state == ST_IDLE) ? eff_len : len_q;
`else
  assign st_frame = eff_frame;
  assign st_len   = eff_len;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      rdy      <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SQ_TX_REPEAT_EN
      frame_q  <= '0;
      len_q    <= '0;
      rpt_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.load_valid && rdy) begin
            state    <= ST_SHIFT;
            sreg     <= st_frame << 1;
            bcnt     <= st_len - ONE;
            tx_bit   <= st_frame[WIDTH-1];
            tx_valid <= 1'b1;
            done_q   <= (st_len == ONE);
            rdy      <= 1'b0;
            busy_q   <= 1'b1;
`ifdef SQ_TX_REPEAT_EN
            frame_q  <= eff_frame;
            len_q    <= eff_len;
`endif
          end
        end
        ST_SHIFT: begin
          if (bcnt != '0) begin
            sreg   <= sreg << 1;
            bcnt   <= bcnt - ONE;
            tx_bit <= sreg[WIDTH-1];
            done_q <= (bcnt == ONE);
          end else begin
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            done_q   <= 1'b0;
`ifdef SQ_TX_REPEAT_EN
            rpt_q    <= repeat_frame;
`endif
            if (GAP > 0) begin
              state <= ST_GAP;
              gcnt  <= GAP_LAST;
            end
`ifdef SQ_TX_REPEAT_EN
            else if (repeat_frame) begin
              state    <= ST_SHIFT;
              sreg     <= st_frame << 1;
              bcnt     <= st_len - ONE;
              tx_bit   <= st_frame[WIDTH-1];
              tx_valid <= 1'b1;
              done_q   <= (st_len == ONE);
            end
`endif
            else begin
              state  <= ST_IDLE;
              rdy    <= 1'b1;
              busy_q <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (gcnt != '0) begin
            gcnt <= gcnt - GW'(1);
          end
`ifdef SQ_TX_REPEAT_EN
          else if (rpt_q) begin
            state    <= ST_SHIFT;
            sreg     <= st_frame << 1;
            bcnt     <= st_len - ONE;
            tx_bit   <= st_frame[WIDTH-1];
            tx_valid <= 1'b1;
            done_q   <= (st_len == ONE);
          end
`endif
          else begin
            state  <= ST_IDLE;
            rdy    <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready = rdy;
  assign bus.out_data   = tx_bit;
  assign bus.out_valid  = tx_valid;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sq_stream_tx.sv
// tb_sq_stream_tx: randomized bench for sq_stream_tx against a
// queue-of-expected-cycles reference model.
module tb_sq_stream_tx;
  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SQ_TX_REPEAT_EN
  logic repeat_frame = 1'b0;
`endif

  always #5 clk = ~clk;

  sq_stream_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  sq_stream_tx #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W),
    .GAP  (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SQ_TX_REPEAT_EN
    .repeat_frame(repeat_frame),
`endif
    .bus         (bus)
  );

  // One entry per expected busy cycle; empty queue means idle.
  typedef struct packed {
    logic v;
    logic d;
    logic dn;
  } item_t;

  item_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
`ifdef SQ_TX_REPEAT_EN
  logic [WIDTH-1:0] rep_data;
  logic [LEN_W-1:0] rep_len;
`endif

  function automatic int eff(input logic [LEN_W-1:0] len);
    if (len == '0 || len > WIDTH) return WIDTH;
    return int'(len);
  endfunction

  task automatic push_frame(input logic [WIDTH-1:0] data,
                            input logic [LEN_W-1:0] len);
    int l;
    l = eff(len);
    for (int i = l - 1; i >= 0; i--)
      exp_q.push_back('{v: 1'b1, d: data[i], dn: (i == 0)});
    for (int g = 0; g < GAP; g++)
      exp_q.push_back('{v: 1'b0, d: 1'b0, dn: 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
`ifdef SQ_TX_REPEAT_EN
      if (exp_q[0].dn && repeat_frame)
        push_frame(rep_data, rep_len);
`endif
      void'(exp_q.pop_front());
    end else if (bus.load_valid) begin
`ifdef SQ_TX_REPEAT_EN
      rep_data = bus.load_data;
      rep_len  = bus.load_len;
`endif
      push_frame(bus.load_data, bus.load_len);
    end
    #1;
  endtask

  // {out_valid, out_data, done, load_ready, busy}
  function automatic logic [4:0] exp_outs();
    if (exp_q.size() == 0) return 5'b00010;
    return {exp_q[0].v, exp_q[0].d, exp_q[0].dn, 2'b01};
  endfunction

  function automatic logic [4:0] obs();
    return {bus.out_valid, bus.out_data, bus.done,
            bus.load_ready, bus.busy};
  endfunction

  task automatic drive(input logic v,
                       input logic [WIDTH-1:0] d,
                       input logic [LEN_W-1:0] l);
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_len   = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, WIDTH'($urandom), 5'd8);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (obs() !== 5'b00010)
        $display("FAIL reset k=%0d got %b want 00010", k, obs());
      else n_pass++;
    end
    rst = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    n_checks++;
    if (obs() !== exp_outs())
      $display("FAIL post_reset got %b want %b", obs(), exp_outs());
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] got = '0;
    int nb = 0, done_at = -1, ready_at = -1;
    drive(1'b1, 16'h00B6, 5'd8);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL basic k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
      if (bus.out_valid) begin
        got = {got[6:0], bus.out_data};
        nb++;
      end
      if (bus.done) done_at = k;
      if (bus.load_ready && ready_at < 0) ready_at = k;
    end
    n_checks++;
    if (got !== 8'hB6 || nb != 8)
      $display("FAIL basic_bits got %h/%0d want b6/8", got, nb);
    else n_pass++;
    n_checks++;
    if (done_at != 8 || ready_at != GAP + 9)
      $display("FAIL basic_timing done %0d ready %0d want 8 %0d",
               done_at, ready_at, GAP + 9);
    else n_pass++;
  endtask

  task automatic test_ignored_load();
    logic [7:0] got = '0;
    drive(1'b1, 16'h00B6, 5'd8);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL ignored k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
      if (bus.out_valid) got = {got[6:0], bus.out_data};
      if (k == 3) drive(1'b1, 16'hFFFF, 5'd4);
    end
    n_checks++;
    if (got !== 8'hB6)
      $display("FAIL ignored_bits got %h want b6", got);
    else n_pass++;
    tick();
    drive(1'b0, '0, '0);
    n_checks++;
    if (obs() !== 5'b11001)
      $display("FAIL ignored_next got %b want 11001", obs());
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL ignored_drain k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
    end
  endtask

  task automatic test_full_len();
    logic [LEN_W-1:0] lens [2];
    lens[0] = 5'd0;
    lens[1] = 5'd20;
    for (int t = 0; t < 2; t++) begin
      logic [15:0] got = '0;
      int done_at = -1;
      drive(1'b1, 16'hA5F0, lens[t]);
      tick();
      drive(1'b0, '0, '0);
      for (int k = 1; k <= 19; k++) begin
        if (k > 1) tick();
        n_checks++;
        if (obs() !== exp_outs())
          $display("FAIL full k=%0d got %b want %b",
                   k, obs(), exp_outs());
        else n_pass++;
        if (bus.out_valid) got = {got[14:0], bus.out_data};
        if (bus.done) done_at = k;
      end
      n_checks++;
      if (got !== 16'hA5F0 || done_at != 16)
        $display("FAIL full_bits len=%0d got %h done %0d want a5f0 16",
                 lens[t], got, done_at);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] got = '0;
    int n_done = 0;
    drive(1'b1, WIDTH'($urandom), 5'd8);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL rst_mid k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs() !== 5'b00010)
      $display("FAIL rst_mid_abort got %b want 00010", obs());
    else n_pass++;
    drive(1'b1, 16'h0003, 5'd2);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL rst_mid_next k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
      if (bus.out_valid) got = {got[0], bus.out_data};
      if (bus.done) n_done++;
    end
    n_checks++;
    if (got !== 2'b11 || n_done != 1)
      $display("FAIL rst_mid_bits got %b done %0d want 11 1",
               got, n_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int last_done = -1, n_turn = 0;
    logic prev_v = 1'b0;
    drive(1'b1, WIDTH'($urandom), 5'd3);
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL b2b k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
      if (bus.out_valid && !prev_v && last_done >= 0) begin
        n_turn++;
        n_checks++;
        if (k - last_done != GAP + 2)
          $display("FAIL b2b_turn got %0d want %0d",
                   k - last_done, GAP + 2);
        else n_pass++;
      end
      if (bus.done) last_done = k;
      prev_v = bus.out_valid;
      drive(1'b1, WIDTH'($urandom), 5'd3);
    end
    drive(1'b0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL b2b_drain k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
    end
    n_checks++;
    if (n_turn != 3)
      $display("FAIL b2b_count got %0d want 3", n_turn);
    else n_pass++;
  endtask

  task automatic test_random();
    int guard = 0;
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(63) == 0);
`ifdef SQ_TX_REPEAT_EN
      repeat_frame = ($urandom_range(3) == 0);
`endif
      drive(1'($urandom_range(1)), WIDTH'($urandom),
            LEN_W'($urandom));
      tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL random k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
    end
    rst = 1'b0;
`ifdef SQ_TX_REPEAT_EN
    repeat_frame = 1'b0;
`endif
    drive(1'b0, '0, '0);
    while (exp_q.size() != 0 && guard < 80) begin
      tick();
      guard++;
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL random_drain got %b want %b",
                 obs(), exp_outs());
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.load_ready !== 1'b1)
      $display("FAIL random_timeout left %0d ready %b want 0 1",
               exp_q.size(), bus.load_ready);
    else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0] fr = 8'hB6;
    logic [3:0] w = '0;
    logic [3:0] det = '0;
    int exp_fires = 0, exp_first = -1;
    int fires = 0, first = -1, nb = 0;
    for (int i = 7; i >= 0; i--) begin
      w = {w[2:0], fr[i]};
      if (w == 4'b1011) begin
        exp_fires++;
        if (exp_first < 0) exp_first = 7 - i;
      end
    end
    drive(1'b1, {8'h00, fr}, 5'd8);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL loop k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
      det = {det[2:0], bus.out_data};
      if (det == 4'b1011) begin
        fires++;
        if (first < 0) first = nb;
      end
      if (bus.out_valid) nb++;
    end
    n_checks++;
    if (fires != exp_fires || first != exp_first)
      $display("FAIL loop_detect got %0d@%0d want %0d@%0d",
               fires, first, exp_fires, exp_first);
    else n_pass++;
  endtask

`ifdef SQ_TX_REPEAT_EN
  task automatic test_repeat();
    int n_done = 0, nb = 0;
    drive(1'b1, 16'h002D, 5'd6);
    repeat_frame = 1'b1;
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs() !== exp_outs())
        $display("FAIL repeat k=%0d got %b want %b",
                 k, obs(), exp_outs());
      else n_pass++;
      if (bus.out_valid) nb++;
      if (bus.done) n_done++;
      if (n_done == 3) repeat_frame = 1'b0;
    end
    n_checks++;
    if (n_done != 3 || nb != 18)
      $display("FAIL repeat_count got %0d/%0d want 3/18",
               n_done, nb);
    else n_pass++;
  endtask
`endif

  initial begin
    drive(1'b0, '0, '0);
    test_reset();
    test_basic();
    test_ignored_load();
    test_full_len();
    test_reset_mid();
    test_back_to_back();
    test_loopback();
`ifdef SQ_TX_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
